ripple_carry_adder_routing: RTL and testbench
=============================================

RIPPLE_CARRY_ADDER_ROUTING -- requirements
Module: ripple_carry_adder_routing

Interface
REQ-001 Parameter WIDTH, default 32: operand and sum width; all requirements and verification use 32.
REQ-002 The design SHALL use one clock and one reset; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for the output registers only.
REQ-004 rst  input  1  synchronous, active-high reset for the output registers.
REQ-005 a  input  WIDTH  operand A, two's-complement signed.
REQ-006 b  input  WIDTH  operand B, two's-complement signed.
REQ-007 cin  input  1  carry-in to bit 0.
REQ-008 sum  output  WIDTH  combinational a+b+cin, modulo 2^WIDTH.
REQ-009 cout  output  1  combinational carry out of bit WIDTH-1.
REQ-010 overflow  output  1  combinational signed-overflow flag.
REQ-011 sum_q  output  WIDTH  registered copy of sum.
REQ-012 cout_q  output  1  registered copy of cout.
REQ-013 overflow_q  output  1  registered copy of overflow.

Function
REQ-014 Adder SHALL be a ripple-carry chain of WIDTH one-bit full adders; carry of bit i feeds bit i+1; c[0]=cin.
REQ-015 Each full adder: s = a_i XOR b_i XOR c_i; c_out = (a_i AND b_i) OR (c_i AND (a_i XOR b_i)).
REQ-016 sum, cout, overflow SHALL be purely combinational from a, b, cin: zero-cycle latency, valid after ripple propagation, independent of clk and rst.
REQ-017 cout = carry out of bit WIDTH-1 (unsigned carry).
REQ-018 overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1; equivalently, a and b have the same sign and sum has the opposite sign, with cin included in the add.
REQ-019 Wrap-around: the sum SHALL wrap modulo 2^WIDTH with no saturation; overflow only flags the wrap.
REQ-020 On each rising clk edge with rst=0: sum_q<=sum, cout_q<=cout, overflow_q<=overflow, giving one-cycle latency.
REQ-021 The combinational outputs SHALL NOT depend on the register state: no feedback from *_q into the adder.
REQ-022 No X propagation: with known inputs, all outputs SHALL be known.

Reset
REQ-023 On a rising clk edge with rst=1: sum_q<=0, cout_q<=0, overflow_q<=0.
REQ-024 rst SHALL NOT affect sum, cout or overflow.
REQ-025 Before the first reset edge, *_q are undefined; the combinational outputs are valid without any clock or reset.
REQ-026 If rst is asserted in the same cycle as new operands, reset wins for *_q; the operands are not captured.

Verification
REQ-027 Hold clk=0; apply a=0x7FFFFFFF, b=1, cin=0; wait 10 time units -> sum=0x80000000 (-2147483648), overflow=1, cout=0.
REQ-028 Hold clk=0; a=-2147483648, b=-1, cin=0 -> sum=2147483647, overflow=1, cout=1.
REQ-029 Combinational cases, each with overflow=0:
- a=100, b=-50 -> sum=50
- a=12345, b=54321 -> sum=66666
- a=-12345, b=-54321 -> sum=-66666
- a=123456, b=-654321 -> sum=-530865
- a=-100000, b=99999 -> sum=-1
- a=0, b=0 -> sum=0, cout=0
REQ-030 cin path: a=0xFFFFFFFF, b=0, cin=1 -> sum=0, cout=1, overflow=0; a=0x7FFFFFFF, b=0, cin=1 -> sum=0x80000000, overflow=1.
REQ-031 Registered path:
- rst=1 for one edge -> sum_q=0, cout_q=0, overflow_q=0.
- rst=0, a=5, b=7, cin=0: before the next edge sum_q=0; after the next edge sum_q=12.
- Assert rst with inputs non-zero -> *_q=0 at the next edge while sum stays 12.
REQ-032 Random check: 1000 random a, b, cin -> sum equals (a+b+cin) mod 2^32, cout equals bit 32 of the 33-bit unsigned sum, overflow matches REQ-018; one cycle later, *_q equal the prior combinational values.

Source files
------------

// File: rtl/ripple_carry_adder_routing.sv
// Ripple-carry adder built from WIDTH explicit one-bit full adders, with a combinational
// result path and a one-cycle registered copy of sum, carry-out and signed overflow.
module ripple_carry_adder_routing #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             overflow_q
);

  // carry[i] is the carry into bit i; carry[WIDTH] is the carry out of the MSB.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] prop;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign prop[i]      = a[i] ^ b[i];
    assign sum[i]       = prop[i] ^ carry[i];
    assign carry[i+1]   = (a[i] & b[i]) | (carry[i] & prop[i]);
  end

  assign cout     = carry[WIDTH];
  // Signed overflow: carry into the sign bit disagrees with carry out of it.
  assign overflow = carry[WIDTH] ^ carry[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q      <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      sum_q      <= sum;
      cout_q     <= cout;
      overflow_q <= overflow;
    end
  end

endmodule

// File: tb/tb_ripple_carry_adder_routing.sv
// Self-checking bench: directed corner cases with the clock held low, the registered
// path around reset, then randomized operands against an arithmetic reference.
module tb_ripple_carry_adder_routing;

  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             clk_run;
  logic             rst;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             overflow_q;

  int n_vectors;
  int n_miscompares;

  ripple_carry_adder_routing #(
    .WIDTH(WIDTH)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .b          (b),
    .cin        (cin),
    .sum        (sum),
    .cout       (cout),
    .overflow   (overflow),
    .sum_q      (sum_q),
    .cout_q     (cout_q),
    .overflow_q (overflow_q)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] observed,
                          input logic [63:0] expected);
    n_vectors++;
    if (observed !== expected) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: plain 33-bit unsigned add, signed overflow from operand/result signs.
  task automatic model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                       input logic mcin, output logic [WIDTH-1:0] msum,
                       output logic mcout, output logic movf);
    logic [WIDTH:0] full;
    full  = {1'b0, ma} + {1'b0, mb} + {{WIDTH{1'b0}}, mcin};
    msum  = full[WIDTH-1:0];
    mcout = full[WIDTH];
    movf  = (ma[WIDTH-1] == mb[WIDTH-1]) && (msum[WIDTH-1] != ma[WIDTH-1]);
  endtask

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } vec_t;

  vec_t dir[10];

  logic [WIDTH-1:0] e_sum;
  logic             e_cout;
  logic             e_ovf;

  initial begin
    n_vectors     = 0;
    n_miscompares = 0;
    clk_run       = 1'b0;
    rst           = 1'b0;
    a             = '0;
    b             = '0;
    cin           = 1'b0;

    dir[0] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    dir[1] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};
    dir[2] = '{32'd100, -32'sd50, 1'b0, 32'd50, 1'b1, 1'b0};
    dir[3] = '{32'd12345, 32'd54321, 1'b0, 32'd66666, 1'b0, 1'b0};
    dir[4] = '{-32'sd12345, -32'sd54321, 1'b0, -32'sd66666, 1'b1, 1'b0};
    dir[5] = '{32'd123456, -32'sd654321, 1'b0, -32'sd530865, 1'b0, 1'b0};
    dir[6] = '{-32'sd100000, 32'd99999, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0};
    dir[7] = '{32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0};
    dir[8] = '{32'hFFFF_FFFF, 32'd0, 1'b1, 32'd0, 1'b1, 1'b0};
    dir[9] = '{32'h7FFF_FFFF, 32'd0, 1'b1, 32'h8000_0000, 1'b0, 1'b1};

    // Combinational path with no clock activity and no reset ever applied.
    for (int i = 0; i < 10; i++) begin
      a   = dir[i].a;
      b   = dir[i].b;
      cin = dir[i].cin;
      #10;
      check_eq($sformatf("dir%0d_sum", i), 64'(sum), 64'(dir[i].sum));
      check_eq($sformatf("dir%0d_cout", i), 64'(cout), 64'(dir[i].cout));
      check_eq($sformatf("dir%0d_ovf", i), 64'(overflow), 64'(dir[i].ovf));
    end

    // Registered path: reset, capture, reset-wins.
    clk_run = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_sum_q", 64'(sum_q), 64'd0);
    check_eq("rst_cout_q", 64'(cout_q), 64'd0);
    check_eq("rst_ovf_q", 64'(overflow_q), 64'd0);

    @(negedge clk);
    rst = 1'b0;
    a   = 32'd5;
    b   = 32'd7;
    cin = 1'b0;
    #1;
    check_eq("pre_edge_sum_q", 64'(sum_q), 64'd0);
    check_eq("comb_sum_5_7", 64'(sum), 64'd12);
    @(posedge clk);
    #1;
    check_eq("post_edge_sum_q", 64'(sum_q), 64'd12);

    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_wins_sum_q", 64'(sum_q), 64'd0);
    check_eq("rst_wins_cout_q", 64'(cout_q), 64'd0);
    check_eq("rst_wins_ovf_q", 64'(overflow_q), 64'd0);
    check_eq("rst_keeps_sum", 64'(sum), 64'd12);

    @(negedge clk);
    rst = 1'b0;

    // Random operands; registered copy checked one edge later.
    for (int i = 0; i < 1000; i++) begin
      a   = $urandom;
      b   = $urandom;
      cin = 1'($urandom_range(0, 1));
      // Bias some vectors toward sign-boundary operands.
      if (i % 8 == 0) a[WIDTH-2:0] = {(WIDTH-1){a[0]}};
      #1;
      model(a, b, cin, e_sum, e_cout, e_ovf);
      check_eq("rnd_sum", 64'(sum), 64'(e_sum));
      check_eq("rnd_cout", 64'(cout), 64'(e_cout));
      check_eq("rnd_ovf", 64'(overflow), 64'(e_ovf));
      @(posedge clk);
      #1;
      check_eq("rnd_sum_q", 64'(sum_q), 64'(e_sum));
      check_eq("rnd_cout_q", 64'(cout_q), 64'(e_cout));
      check_eq("rnd_ovf_q", 64'(overflow_q), 64'(e_ovf));
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
